rbt_s_hdr_rr_arbiter: RTL
=========================

// Module: rbt_s_hdr_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one proto-header parse path (pre-parser input) among N header
//  sources (e.g. per-port header extractors). Selects one valid requester per accepted
//  transfer, registers the selected header/length/pktlen/tuser/meta into a single output
//  stage, and reports the winning source index. Sits directly upstream of the pre-parser.
// PARAMETERS
//  N_PORTS       4     number of requesting header sources (2..16)
//  HEADER_WIDTH  2048  header data width per source (multiple of 8)
//  USER_WIDTH    36    tuser width per source
//  META_WIDTH    32    meta width per source
//  IDX_WIDTH     $clog2(N_PORTS)  width of grant index (min 1)
// PORTS
//  clk                 in   1                      clock
//  rst                 in   1                      synchronous, active-high reset
//  in_hdr_valid        in   N_PORTS                per-source valid
//  in_hdr_ready        out  N_PORTS                per-source ready (at most one high)
//  in_hdr_length       in   16*N_PORTS             header length, source i at [16*i +: 16]
//  in_hdr_pktlen       in   16*N_PORTS             packet length, same packing
//  in_hdr_data         in   HEADER_WIDTH*N_PORTS   header data, same packing
//  in_hdr_tuser        in   USER_WIDTH*N_PORTS     tuser, same packing
//  in_hdr_meta         in   META_WIDTH*N_PORTS     meta, same packing
//  out_hdr_valid       out  1                      output stage holds a header
//  out_hdr_ready       in   1                      downstream (pre-parser) accepts
//  out_hdr_length/pktlen/data/tuser/meta  out  16/16/HEADER_WIDTH/USER_WIDTH/META_WIDTH  registered copy
//  out_hdr_src         out  IDX_WIDTH              index of source that supplied the header
//  grant_cnt           out  32*N_PORTS             per-source accepted-transfer counter, wraps
// BEHAVIOUR
//  - Reset: out_hdr_valid=0, all out_hdr_* data/src=0, grant_cnt=0, last_grant=N_PORTS-1
//    (so source 0 has highest priority first). in_hdr_ready=0 while rst high.
//  - load_en = !out_hdr_valid | out_hdr_ready (output stage free or draining this cycle).
//  - Winner: first i with in_hdr_valid[i]=1 scanning last_grant+1, +2, ... wrapping mod N_PORTS.
//    Combinational from in_hdr_valid and last_grant only; no dependency on in data.
//  - in_hdr_ready[winner]=load_en; all other ready bits 0; all 0 if no valid requester.
//  - Transfer on in_hdr_valid[w]&in_hdr_ready[w]: next cycle out_hdr_valid=1, out_hdr_* =
//    source w fields, out_hdr_src=w, last_grant<=w, grant_cnt[w]++ (32-bit wrap to 0).
//  - Latency 1 cycle input->output; full throughput (one header/cycle) while out_hdr_ready=1.
//  - out_hdr_ready=1 with no new transfer: out_hdr_valid->0, data fields hold last value.
//  - out_hdr_valid=1 & out_hdr_ready=0: output stage and all fields stable; all in ready=0;
//    last_grant unchanged.
//  - Fairness: a continuously valid source waits at most N_PORTS-1 transfers.
//  - Sources not granted must hold valid/data (AXI-S rule); dropping valid ungranted is legal
//    and simply removes the request.
//  - Single requester: granted every load_en cycle regardless of last_grant.
//  - Reset mid-operation: pending output header discarded, no ready asserted that cycle.
// TESTING (N_PORTS=4)
//  1. Reset, then valid=4'b0001, length=64: ready[0]=1 same cycle; next cycle out_valid=1,
//     length=64, src=0; grant_cnt[0]=1.
//  2. All 4 valid continuously, out_ready=1: src sequence 0,1,2,3,0,1 on consecutive cycles.
//  3. Valid=4'b1010 after last_grant=1: grant 3 then 1 then 3; ports 0,2 never ready.
//  4. out_ready=0 for 5 cycles with out_valid=1: all in ready=0, out fields stable; on
//     out_ready=1 next winner loads same cycle (back-to-back, no bubble).
//  5. Assert rst while out_valid=1 and valid=4'b1111: next cycle out_valid=0, grant_cnt=0;
//     after release first grant is source 0.
//  6. Force grant_cnt[2]=32'hFFFFFFFF, grant port 2 once -> grant_cnt[2]=0.

Source files
------------

// File: rtl/rbt_s_hdr_rr_arbiter_if.sv
// Bundle of per-source header request buses and the single registered output stage
// of the round-robin header arbiter.
interface rbt_s_hdr_rr_arbiter_if #(
    parameter int N_PORTS      = 4,
    parameter int HEADER_WIDTH = 2048,
    parameter int USER_WIDTH   = 36,
    parameter int META_WIDTH   = 32,
    parameter int IDX_WIDTH    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
);
  logic [N_PORTS-1:0]              in_hdr_valid;
  logic [N_PORTS-1:0]              in_hdr_ready;
  logic [16*N_PORTS-1:0]           in_hdr_length;
  logic [16*N_PORTS-1:0]           in_hdr_pktlen;
  logic [HEADER_WIDTH*N_PORTS-1:0] in_hdr_data;
  logic [USER_WIDTH*N_PORTS-1:0]   in_hdr_tuser;
  logic [META_WIDTH*N_PORTS-1:0]   in_hdr_meta;

  logic                    out_hdr_valid;
  logic                    out_hdr_ready;
  logic [15:0]             out_hdr_length;
  logic [15:0]             out_hdr_pktlen;
  logic [HEADER_WIDTH-1:0] out_hdr_data;
  logic [USER_WIDTH-1:0]   out_hdr_tuser;
  logic [META_WIDTH-1:0]   out_hdr_meta;
  logic [IDX_WIDTH-1:0]    out_hdr_src;
  logic [32*N_PORTS-1:0]   grant_cnt;

  modport master (
    output in_hdr_valid, in_hdr_length, in_hdr_pktlen, in_hdr_data, in_hdr_tuser, in_hdr_meta,
    input  in_hdr_ready,
    input  out_hdr_valid, out_hdr_length, out_hdr_pktlen, out_hdr_data, out_hdr_tuser,
    input  out_hdr_meta, out_hdr_src, grant_cnt,
    output out_hdr_ready
  );

  modport slave (
    input  in_hdr_valid, in_hdr_length, in_hdr_pktlen, in_hdr_data, in_hdr_tuser, in_hdr_meta,
    output in_hdr_ready,
    output out_hdr_valid, out_hdr_length, out_hdr_pktlen, out_hdr_data, out_hdr_tuser,
    output out_hdr_meta, out_hdr_src, grant_cnt,
    input  out_hdr_ready
  );
endinterface

// File: rtl/rbt_s_hdr_rr_arbiter.sv
// Round-robin arbiter sharing one header parse path among N_PORTS header sources,
// with a single registered output stage and per-source grant counters.
module rbt_s_hdr_rr_arbiter #(
    parameter int N_PORTS      = 4,
    parameter int HEADER_WIDTH = 2048,
    parameter int USER_WIDTH   = 36,
    parameter int META_WIDTH   = 32,
    parameter int IDX_WIDTH    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input logic clk,
  input logic rst,
  rbt_s_hdr_rr_arbiter_if.slave bus
);

  logic                    out_valid_r;
  logic [15:0]             out_length_r;
  logic [15:0]             out_pktlen_r;
  logic [HEADER_WIDTH-1:0] out_data_r;
  logic [USER_WIDTH-1:0]   out_tuser_r;
  logic [META_WIDTH-1:0]   out_meta_r;
  logic [IDX_WIDTH-1:0]    out_src_r;
  logic [IDX_WIDTH-1:0]    last_grant_r;
  logic [32*N_PORTS-1:0]   cnt_r;

  logic                    load_en_s;
  logic                    found_s;
  logic                    xfer_s;
  logic [IDX_WIDTH-1:0]    win_s;
  logic [15:0]             sel_length_s;
  logic [15:0]             sel_pktlen_s;
  logic [HEADER_WIDTH-1:0] sel_data_s;
  logic [USER_WIDTH-1:0]   sel_tuser_s;
  logic [META_WIDTH-1:0]   sel_meta_s;

  assign load_en_s = !out_valid_r || bus.out_hdr_ready;
  assign xfer_s    = found_s && load_en_s;

  // Winner search: scan from the source after the last grant, wrapping; pick up its fields.
  always_comb begin
    int idx_v;
    idx_v        = 0;
    found_s      = 1'b0;
    win_s        = '0;
    sel_length_s = '0;
    sel_pktlen_s = '0;
    sel_data_s   = '0;
    sel_tuser_s  = '0;
    sel_meta_s   = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      idx_v = (int'(last_grant_r) + k) % N_PORTS;
      if (!found_s && bus.in_hdr_valid[idx_v]) begin
        found_s      = 1'b1;
        win_s        = IDX_WIDTH'(idx_v);
        sel_length_s = bus.in_hdr_length[16*idx_v +: 16];
        sel_pktlen_s = bus.in_hdr_pktlen[16*idx_v +: 16];
        sel_data_s   = bus.in_hdr_data[HEADER_WIDTH*idx_v +: HEADER_WIDTH];
        sel_tuser_s  = bus.in_hdr_tuser[USER_WIDTH*idx_v +: USER_WIDTH];
        sel_meta_s   = bus.in_hdr_meta[META_WIDTH*idx_v +: META_WIDTH];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Ready is steered to the winner only; suppressed during reset.
  always_comb begin
    bus.in_hdr_ready = '0;
    if (xfer_s && !rst) begin
      bus.in_hdr_ready[win_s] = 1'b1;
    end else begin
      bus.in_hdr_ready = '0;
    end
  end

  // Output stage, round-robin pointer and grant counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_length_r <= 16'd0;
      out_pktlen_r <= 16'd0;
      out_data_r   <= '0;
      out_tuser_r  <= '0;
      out_meta_r   <= '0;
      out_src_r    <= '0;
      last_grant_r <= IDX_WIDTH'(N_PORTS - 1);
      cnt_r        <= '0;
    end else if (load_en_s) begin
      out_valid_r <= found_s;
      if (found_s) begin
        out_length_r <= sel_length_s;
        out_pktlen_r <= sel_pktlen_s;
        out_data_r   <= sel_data_s;
        out_tuser_r  <= sel_tuser_s;
        out_meta_r   <= sel_meta_s;
        out_src_r    <= win_s;
        last_grant_r <= win_s;
        for (int i = 0; i < N_PORTS; i++) begin
          if (IDX_WIDTH'(i) == win_s) begin
            cnt_r[32*i +: 32] <= cnt_r[32*i +: 32] + 32'd1;
          end
        end
      end
    end
  end

  assign bus.out_hdr_valid  = out_valid_r;
  assign bus.out_hdr_length = out_length_r;
  assign bus.out_hdr_pktlen = out_pktlen_r;
  assign bus.out_hdr_data   = out_data_r;
  assign bus.out_hdr_tuser  = out_tuser_r;
  assign bus.out_hdr_meta   = out_meta_r;
  assign bus.out_hdr_src    = out_src_r;
  assign bus.grant_cnt      = cnt_r;

endmodule
